// File: rtl/adder_pkg.sv
// Shared constants and types for the adder sink: AXIS field widths, default
// node address and the sink FSM state encoding.
package adder_pkg;

   localparam int DATAW = 128;
   localparam int DESTW = 4;
   localparam int IDW   = 32;
   localparam int STRBW = 8;
   localparam int KEEPW = 8;
   localparam int USERW = 66;

   localparam logic [DESTW-1:0] NODE_ADDR_DEFAULT = 4'b0011;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      RESULT
   } adderState_t;

endpackage

// File: rtl/adder_acc_dp.sv
// Accumulator datapath: running sum, saturating beat counter and, when
// ADDER_SINK_OVERFLOW_EN is defined, a sticky carry-out flag.
module adder_acc_dp #(
   parameter int DATAW = 128,
   parameter int CNTW  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             add_i,
   input  logic             clear_i,
   input  logic [DATAW-1:0] data_i,
   output logic [DATAW-1:0] acc_o,
   output logic [CNTW-1:0]  beats_o,
   output logic             overflow_o
);

   logic [DATAW-1:0] acc_q, acc_d;
   logic [CNTW-1:0]  beats_q, beats_d;
   logic [DATAW:0]   sum;

   assign sum = {1'b0, acc_q} + {1'b0, data_i};

   always_comb begin
      acc_d   = acc_q;
      beats_d = beats_q;
      if (clear_i) begin
         acc_d   = '0;
         beats_d = '0;
      end else if (load_i) begin
         acc_d   = data_i;
         beats_d = CNTW'(1);
      end else if (add_i) begin
         acc_d = sum[DATAW-1:0];
         // Counter sticks at all-ones rather than wrapping back to zero.
         if (beats_q != '1) begin
            beats_d = beats_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q   <= '0;
         beats_q <= '0;
      end else begin
         acc_q   <= acc_d;
         beats_q <= beats_d;
      end
   end

   assign acc_o   = acc_q;
   assign beats_o = beats_q;

`ifdef ADDER_SINK_OVERFLOW_EN
   logic overflow_q, overflow_d;

   always_comb begin
      overflow_d = overflow_q;
      if (clear_i || load_i) begin
         overflow_d = 1'b0;
      end else if (add_i) begin
         overflow_d = overflow_q | sum[DATAW];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign overflow_o = overflow_q;
`else
   logic unusedCarry;
   assign unusedCarry = sum[DATAW];
   assign overflow_o  = 1'b0;
`endif

endmodule

// File: rtl/adder_sink.sv
// NoC stream sink that sums the operands of each transaction addressed to this
// node and presents the total on a valid/ready response port.
// Optional overflow reporting is enabled with ADDER_SINK_OVERFLOW_EN.
module adder_sink
   import adder_pkg::*;
#(
   parameter int               DATAW     = adder_pkg::DATAW,
   parameter logic [DESTW-1:0] NODE_ADDR = NODE_ADDR_DEFAULT,
   parameter int               CNTW      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             axis_adder_interface_tvalid,
   output logic             axis_adder_interface_tready,
   input  logic             axis_adder_interface_tlast,
   input  logic [DESTW-1:0] axis_adder_interface_tdest,
   input  logic [IDW-1:0]   axis_adder_interface_tid,
   input  logic [STRBW-1:0] axis_adder_interface_tstrb,
   input  logic [KEEPW-1:0] axis_adder_interface_tkeep,
   input  logic [USERW-1:0] axis_adder_interface_tuser,
   input  logic [DATAW-1:0] axis_adder_interface_tdata,
   output logic             response_valid,
   input  logic             response_ready,
   output logic [DATAW-1:0] response_data,
   output logic [CNTW-1:0]  response_beats,
   output logic             response_overflow
);

   adderState_t state_q, state_d;
   logic        tready_q;
   logic        beatMatch;
   logic        load, add, clear;
   logic [DATAW-1:0] acc;
   logic [CNTW-1:0]  beats;
   logic             overflow;

   logic unusedSideband;
   assign unusedSideband = ^{axis_adder_interface_tid, axis_adder_interface_tstrb,
                             axis_adder_interface_tkeep, axis_adder_interface_tuser};

   // Off-address beats are still accepted (tready) but never reach the datapath.
   assign beatMatch = axis_adder_interface_tvalid && tready_q &&
                      (axis_adder_interface_tdest == NODE_ADDR);

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      add     = 1'b0;
      clear   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (beatMatch) begin
               load    = 1'b1;
               state_d = axis_adder_interface_tlast ? RESULT : ACCUM;
            end
         end
         ACCUM: begin
            if (beatMatch) begin
               add = 1'b1;
               if (axis_adder_interface_tlast) begin
                  state_d = RESULT;
               end
            end
         end
         RESULT: begin
            if (response_ready) begin
               clear   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // tready is registered so it stays low in reset and rises on the first edge after.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         tready_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tready_q <= (state_d != RESULT);
      end
   end

   adder_acc_dp #(
      .DATAW (DATAW),
      .CNTW  (CNTW)
   ) u_acc_dp (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load),
      .add_i      (add),
      .clear_i    (clear),
      .data_i     (axis_adder_interface_tdata),
      .acc_o      (acc),
      .beats_o    (beats),
      .overflow_o (overflow)
   );

   assign axis_adder_interface_tready = tready_q;
   assign response_valid    = (state_q == RESULT);
   assign response_data     = response_valid ? acc : '0;
   assign response_beats    = response_valid ? beats : '0;
   assign response_overflow = response_valid & overflow;

endmodule

// File: tb/tb_adder_sink.sv
// Directed self-checking bench for adder_sink: hand-computed sums for
// matching, off-address, single-beat, overflow, backpressure and reset cases.
module tb_adder_sink;

   logic         clk;
   logic         rst;
   logic         tvalid;
   logic         tready;
   logic         tlast;
   logic [3:0]   tdest;
   logic [31:0]  tid;
   logic [7:0]   tstrb;
   logic [7:0]   tkeep;
   logic [65:0]  tuser;
   logic [127:0] tdata;
   logic         respValid;
   logic         respReady;
   logic [127:0] respData;
   logic [15:0]  respBeats;
   logic         respOverflow;

   int errorCount;
   int checkCount;
   logic expOverflow;

   adder_sink dut (
      .clk                         (clk),
      .rst                         (rst),
      .axis_adder_interface_tvalid (tvalid),
      .axis_adder_interface_tready (tready),
      .axis_adder_interface_tlast  (tlast),
      .axis_adder_interface_tdest  (tdest),
      .axis_adder_interface_tid    (tid),
      .axis_adder_interface_tstrb  (tstrb),
      .axis_adder_interface_tkeep  (tkeep),
      .axis_adder_interface_tuser  (tuser),
      .axis_adder_interface_tdata  (tdata),
      .response_valid              (respValid),
      .response_ready              (respReady),
      .response_data               (respData),
      .response_beats              (respBeats),
      .response_overflow           (respOverflow)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Present one beat at a falling edge and hold it until it has been accepted.
   task automatic applyStimulus(input logic [127:0] data, input logic [3:0] dest,
                                input logic last);
      int waitCycles;
      tdata  = data;
      tdest  = dest;
      tlast  = last;
      tvalid = 1'b1;
      waitCycles = 0;
      while (!tready && waitCycles < 20) begin
         @(negedge clk);
         waitCycles++;
      end
      if (waitCycles >= 20) begin
         checkOutput("treadyTimeout", 128'(tready), 128'd1);
      end
      @(negedge clk);
      tvalid = 1'b0;
      tlast  = 1'b0;
      tdata  = '0;
   endtask

   task automatic releaseResult(input string tag);
      respReady = 1'b1;
      @(negedge clk);
      respReady = 1'b0;
      checkOutput({tag, "_validDrop"}, 128'(respValid), 128'd0);
      checkOutput({tag, "_treadyBack"}, 128'(tready), 128'd1);
      checkOutput({tag, "_dataZero"}, respData, 128'd0);
   endtask

   initial begin
      errorCount = 0;
      checkCount = 0;
`ifdef ADDER_SINK_OVERFLOW_EN
      expOverflow = 1'b1;
`else
      expOverflow = 1'b0;
`endif
      rst = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdest = 4'd0; tdata = '0;
      tid = '0; tstrb = '0; tkeep = '0; tuser = '0; respReady = 1'b0;

      #2;
      checkOutput("rstTready", 128'(tready), 128'd0);
      checkOutput("rstValid", 128'(respValid), 128'd0);
      checkOutput("rstData", respData, 128'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("rstRelTreadyLow", 128'(tready), 128'd0);
      @(negedge clk);
      checkOutput("firstEdgeTready", 128'(tready), 128'd1);

      // Three-beat sum 5+7+9.
      applyStimulus(128'd5, 4'd3, 1'b0);
      applyStimulus(128'd7, 4'd3, 1'b0);
      checkOutput("midValid", 128'(respValid), 128'd0);
      checkOutput("midDataZero", respData, 128'd0);
      applyStimulus(128'd9, 4'd3, 1'b1);
      checkOutput("sum3Valid", 128'(respValid), 128'd1);
      checkOutput("sum3Data", respData, 128'd21);
      checkOutput("sum3Beats", 128'(respBeats), 128'd3);
      checkOutput("sum3Ovf", 128'(respOverflow), 128'd0);
      checkOutput("sum3Tready", 128'(tready), 128'd0);
      releaseResult("sum3");

      // Wrap-around: all-ones plus 2 leaves 1 with a carry out.
      applyStimulus({128{1'b1}}, 4'd3, 1'b0);
      applyStimulus(128'd2, 4'd3, 1'b1);
      checkOutput("wrapData", respData, 128'd1);
      checkOutput("wrapBeats", 128'(respBeats), 128'd2);
      checkOutput("wrapOvf", 128'(respOverflow), 128'(expOverflow));
      releaseResult("wrap");

      // Off-address beat is consumed and its tlast ignored.
      applyStimulus(128'd10, 4'd3, 1'b0);
      applyStimulus(128'd99, 4'd1, 1'b1);
      checkOutput("foreignNoValid", 128'(respValid), 128'd0);
      checkOutput("foreignTready", 128'(tready), 128'd1);
      applyStimulus(128'd4, 4'd3, 1'b1);
      checkOutput("foreignData", respData, 128'd14);
      checkOutput("foreignBeats", 128'(respBeats), 128'd2);
      releaseResult("foreign");

      // Single beat, then hold off the consumer for five cycles.
      applyStimulus(128'd42, 4'd3, 1'b1);
      checkOutput("singleData", respData, 128'd42);
      checkOutput("singleBeats", 128'(respBeats), 128'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("holdValid", 128'(respValid), 128'd1);
         checkOutput("holdData", respData, 128'd42);
         checkOutput("holdTready", 128'(tready), 128'd0);
      end
      releaseResult("single");

      // Reset after two of three beats discards the partial sum.
      applyStimulus(128'd3, 4'd3, 1'b0);
      applyStimulus(128'd4, 4'd3, 1'b0);
      rst = 1'b0;
      #1;
      checkOutput("midRstTready", 128'(tready), 128'd0);
      checkOutput("midRstValid", 128'(respValid), 128'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("postRstValid", 128'(respValid), 128'd0);
      checkOutput("postRstTready", 128'(tready), 128'd1);
      applyStimulus(128'd1, 4'd3, 1'b0);
      applyStimulus(128'd1, 4'd3, 1'b1);
      checkOutput("postRstData", respData, 128'd2);
      checkOutput("postRstBeats", 128'(respBeats), 128'd2);
      releaseResult("postRst");

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
